// File: rtl/writeback_stage.sv
// Writeback stage: retires one uop per handshake, drives the register-file write port, RFLAGS write
// and scoreboard clear, splitting two-destination results into consecutive low/high writes.
module writeback_stage #(
  parameter int NREGS  = 16,
  parameter int RIDX_W = $clog2(NREGS),
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_dst_en,
  input  logic [RIDX_W-1:0] in_dst_reg,
  input  logic              in_dst2_en,
  input  logic [RIDX_W-1:0] in_dst2_reg,
  input  logic [127:0]      in_result,
  input  logic              in_flags_en,
  input  logic [63:0]       in_flags,
  input  logic [63:0]       in_next_rip,
  input  logic              in_halt,
  output logic              rf_we,
  output logic [RIDX_W-1:0] rf_waddr,
  output logic [63:0]       rf_wdata,
  output logic              flags_we,
  output logic [63:0]       flags_wdata,
  output logic [NREGS-1:0]  sb_clear,
  output logic              retire_valid,
  output logic [63:0]       retire_rip,
  output logic [CNT_W-1:0]  retire_count,
  output logic              halted
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WR_HI = 1'b1;

  function automatic logic [NREGS-1:0] f_onehot(input logic [RIDX_W-1:0] idx);
    logic [NREGS-1:0] v_one;
    v_one    = {{(NREGS-1){1'b0}}, 1'b1};
    f_onehot = v_one << idx;
  endfunction

  logic [0:0]        r_state;
  logic [RIDX_W-1:0] r_dst2_reg;
  logic [63:0]       r_hi_data;
  logic [63:0]       r_next_rip;
  logic              r_halt_pend;

  logic              r_rf_we;
  logic [RIDX_W-1:0] r_rf_waddr;
  logic [63:0]       r_rf_wdata;
  logic              r_flags_we;
  logic [63:0]       r_flags_wdata;
  logic [NREGS-1:0]  r_sb_clear;
  logic              r_retire_valid;
  logic [63:0]       r_retire_rip;
  logic [CNT_W-1:0]  r_retire_count;
  logic              r_halted;

  logic              w_in_ready;
  logic              w_accept;
  logic [0:0]        w_state_nxt;
  logic              w_rf_we_nxt;
  logic [RIDX_W-1:0] w_waddr_nxt;
  logic [63:0]       w_wdata_nxt;
  logic              w_flags_we_nxt;
  logic [63:0]       w_flags_wdata_nxt;
  logic [NREGS-1:0]  w_sb_nxt;
  logic              w_retire_nxt;
  logic [63:0]       w_rip_nxt;
  logic              w_halt_retire;

  assign w_in_ready = (r_state == S_IDLE) && !r_halted;
  assign w_accept   = in_valid && w_in_ready;

  // Next-cycle output values; data outputs hold their last value when no strobe is raised.
  always_comb begin
    w_state_nxt       = r_state;
    w_rf_we_nxt       = 1'b0;
    w_waddr_nxt       = r_rf_waddr;
    w_wdata_nxt       = r_rf_wdata;
    w_flags_we_nxt    = 1'b0;
    w_flags_wdata_nxt = r_flags_wdata;
    w_sb_nxt          = {NREGS{1'b0}};
    w_retire_nxt      = 1'b0;
    w_rip_nxt         = r_retire_rip;
    w_halt_retire     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_rf_we_nxt       = in_dst_en | in_dst2_en;
          w_flags_we_nxt    = in_flags_en;
          w_flags_wdata_nxt = in_flags;
          // The low half always goes first; dst2 only leads when it is the sole destination.
          if (in_dst_en) begin
            w_waddr_nxt = in_dst_reg;
            w_wdata_nxt = in_result[63:0];
            w_sb_nxt    = f_onehot(in_dst_reg);
          end else if (in_dst2_en) begin
            w_waddr_nxt = in_dst2_reg;
            w_wdata_nxt = in_result[127:64];
            w_sb_nxt    = f_onehot(in_dst2_reg);
          end else begin
            w_sb_nxt    = {NREGS{1'b0}};
          end
          if (in_dst_en && in_dst2_en) begin
            w_state_nxt = S_WR_HI;
          end else begin
            w_state_nxt   = S_IDLE;
            w_retire_nxt  = 1'b1;
            w_rip_nxt     = in_next_rip;
            w_halt_retire = in_halt;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WR_HI: begin
        w_state_nxt   = S_IDLE;
        w_rf_we_nxt   = 1'b1;
        w_waddr_nxt   = r_dst2_reg;
        w_wdata_nxt   = r_hi_data;
        w_sb_nxt      = f_onehot(r_dst2_reg);
        w_retire_nxt  = 1'b1;
        w_rip_nxt     = r_next_rip;
        w_halt_retire = r_halt_pend;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and holding registers for the deferred high-half write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dst2_reg  <= {RIDX_W{1'b0}};
      r_hi_data   <= 64'd0;
      r_next_rip  <= 64'd0;
      r_halt_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_dst2_reg  <= in_dst2_reg;
        r_hi_data   <= in_result[127:64];
        r_next_rip  <= in_next_rip;
        r_halt_pend <= in_halt;
      end
    end
  end

  // Registered outputs, retire counter and sticky halt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we        <= 1'b0;
      r_rf_waddr     <= {RIDX_W{1'b0}};
      r_rf_wdata     <= 64'd0;
      r_flags_we     <= 1'b0;
      r_flags_wdata  <= 64'd0;
      r_sb_clear     <= {NREGS{1'b0}};
      r_retire_valid <= 1'b0;
      r_retire_rip   <= 64'd0;
      r_retire_count <= {CNT_W{1'b0}};
      r_halted       <= 1'b0;
    end else begin
      r_rf_we        <= w_rf_we_nxt;
      r_rf_waddr     <= w_waddr_nxt;
      r_rf_wdata     <= w_wdata_nxt;
      r_flags_we     <= w_flags_we_nxt;
      r_flags_wdata  <= w_flags_wdata_nxt;
      r_sb_clear     <= w_sb_nxt;
      r_retire_valid <= w_retire_nxt;
      r_retire_rip   <= w_rip_nxt;
      if (w_retire_nxt) begin
        r_retire_count <= r_retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_halt_retire) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign in_ready     = w_in_ready;
  assign rf_we        = r_rf_we;
  assign rf_waddr     = r_rf_waddr;
  assign rf_wdata     = r_rf_wdata;
  assign flags_we     = r_flags_we;
  assign flags_wdata  = r_flags_wdata;
  assign sb_clear     = r_sb_clear;
  assign retire_valid = r_retire_valid;
  assign retire_rip   = r_retire_rip;
  assign retire_count = r_retire_count;
  assign halted       = r_halted;

endmodule
